// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - round-key sequencer for the on-the-fly AES-128 key expansion unit
// Optional feature macro: KSC_LAST_KEY_EN (adds last_key/last_key_valid for decrypt schedule seeding)
module aes_key_sched_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter bit CHECK_ADDR = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [127:0] req_key,
   input  logic         abort,
   output logic         ke_start,
   output logic [127:0] ke_key,
   output logic         ke_next,
   input  logic [31:0]  ke_round_key,
   input  logic [5:0]   ke_word_addr,
   input  logic         ke_ready,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_round,
   output logic         rk_last,
   output logic         done,
   output logic         busy,
`ifdef KSC_LAST_KEY_EN
   output logic [127:0] last_key,
   output logic         last_key_valid,
`endif
   output logic         err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   state_t       state_q;
   logic [3:0]   round_q;
   logic [1:0]   slot_q;
   logic         next_pend_q;
   logic [31:0]  word_q [4];
   logic         rk_valid_q;
   logic [127:0] rk_data_q;
   logic [3:0]   rk_round_q;
   logic         done_q;
   logic         err_q;
`ifdef KSC_LAST_KEY_EN
   logic [127:0] last_key_q;
   logic         last_key_valid_q;
`endif

   logic accept;
   logic fetch_go;
   logic capture;
   logic addr_bad;
   logic hs;
   logic more;

   always_comb begin
      accept   = (state_q == S_IDLE) && req_valid && !abort;
      fetch_go = (state_q == S_FETCH) && ke_ready && !abort;
      capture  = fetch_go && !next_pend_q;
      addr_bad = CHECK_ADDR && capture && (ke_word_addr != {round_q, slot_q});
      hs       = (state_q == S_PRESENT) && rk_valid_q && rk_ready && !abort;
      more     = (round_q < LAST_RND);
   end

   // A handshake seen while the expansion unit is not ready defers its ke_next into FETCH.
   assign ke_start  = accept;
   assign ke_key    = req_key;
   assign ke_next   = (fetch_go && (next_pend_q || ((slot_q != 2'd3) && !addr_bad)))
                    || (hs && more && ke_ready);
   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rk_valid  = rk_valid_q;
   assign rk_data   = rk_data_q;
   assign rk_round  = rk_round_q;
   assign rk_last   = (rk_round_q == LAST_RND);
   assign done      = done_q;
   assign err       = err_q;
`ifdef KSC_LAST_KEY_EN
   assign last_key       = last_key_q;
   assign last_key_valid = last_key_valid_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         round_q     <= '0;
         slot_q      <= '0;
         next_pend_q <= 1'b0;
         for (int i = 0; i < 4; i++) word_q[i] <= '0;
         rk_valid_q  <= 1'b0;
         rk_data_q   <= '0;
         rk_round_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef KSC_LAST_KEY_EN
         last_key_q       <= '0;
         last_key_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef KSC_LAST_KEY_EN
         if (abort) last_key_valid_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q     <= S_FETCH;
                  round_q     <= '0;
                  slot_q      <= '0;
                  next_pend_q <= 1'b0;
                  err_q       <= 1'b0;
`ifdef KSC_LAST_KEY_EN
                  last_key_valid_q <= 1'b0;
`endif
               end
            end
            S_FETCH: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (ke_ready) begin
                  if (next_pend_q) begin
                     next_pend_q <= 1'b0;
                  end else if (addr_bad) begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     word_q[slot_q] <= ke_round_key;
                     if (slot_q == 2'd3) begin
                        rk_data_q  <= {word_q[0], word_q[1], word_q[2], ke_round_key};
                        rk_round_q <= round_q;
                        rk_valid_q <= 1'b1;
                        slot_q     <= '0;
                        state_q    <= S_PRESENT;
                     end else begin
                        slot_q <= slot_q + 2'd1;
                     end
                  end
               end
            end
            S_PRESENT: begin
               if (abort) begin
                  rk_valid_q <= 1'b0;
                  state_q    <= S_IDLE;
               end else if (hs) begin
                  rk_valid_q <= 1'b0;
                  if (more) begin
                     round_q     <= round_q + 4'd1;
                     next_pend_q <= !ke_ready;
                     state_q     <= S_FETCH;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
`ifdef KSC_LAST_KEY_EN
                     last_key_q       <= rk_data_q;
                     last_key_valid_q <= 1'b1;
`endif
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl with a behavioural expansion unit
module tb_aes_key_sched_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [127:0] req_key = '0;
   logic         abort = 1'b0;
   logic         ke_start;
   logic [127:0] ke_key;
   logic         ke_next;
   logic [31:0]  ke_round_key;
   logic [5:0]   ke_word_addr;
   logic         ke_ready = 1'b1;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_data;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         done;
   logic         busy;
   logic         err;
`ifdef KSC_LAST_KEY_EN
   logic [127:0] last_key;
   logic         last_key_valid;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   always #5 clk = ~clk;

   aes_key_sched_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_key(req_key), .abort(abort), .ke_start(ke_start), .ke_key(ke_key),
      .ke_next(ke_next), .ke_round_key(ke_round_key), .ke_word_addr(ke_word_addr),
      .ke_ready(ke_ready), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
      .rk_round(rk_round), .rk_last(rk_last), .done(done), .busy(busy),
`ifdef KSC_LAST_KEY_EN
      .last_key(last_key), .last_key_valid(last_key_valid),
`endif
      .err(err)
   );

   // AES S-box built from its definition: GF(2^8) inverse followed by the affine map.
   logic [7:0] sbox [256];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, x, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         x = inv;
         s = inv;
         for (int r = 0; r < 4; r++) begin
            x = {x[6:0], x[7]};
            s = s ^ x;
         end
         sbox[a] = s ^ 8'h63;
      end
   endtask

   function automatic logic [0:43][31:0] expand(input logic [127:0] k);
      logic [0:43][31:0] w;
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return w;
   endfunction

   function automatic logic [127:0] exp_rk(input logic [127:0] k, input int r);
      logic [0:43][31:0] w = expand(k);
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Behavioural expansion unit: start loads word 0, next advances one word.
   logic [0:43][31:0] ke_w = '0;
   logic [5:0] kidx = '0;
   int fault_word = -1;

   always @(posedge clk) begin
      if (ke_start) begin
         ke_w <= expand(ke_key);
         kidx <= '0;
      end else if (ke_next && kidx < 6'd43) begin
         kidx <= kidx + 6'd1;
      end
   end
   assign ke_round_key = ke_w[kidx];
   assign ke_word_addr = (fault_word >= 0 && int'(kidx) == fault_word) ? kidx + 6'd1 : kidx;

   int viol = 0;
   int ks_cnt = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (ke_next && !ke_ready) viol++;
         if (ke_next && ke_start) viol++;
         if (busy && (req_ready || ke_start)) viol++;
         if (rk_round > 4'd10) viol++;
         if (ke_start) ks_cnt++;
      end
   end

   logic [127:0] got_rk [16];
   int           got_round [16];
   logic         got_last [16];
   int           got_t [16];
   int           nkeys, end_t, stab_err;
   logic         end_done, end_err;

   task automatic run_sched(input logic [127:0] key, input bit rnd_rk, input bit rnd_ke,
                            input int abort_cyc, input bit hold_req);
      logic         holding = 1'b0;
      logic [127:0] hold_d = '0;
      logic [3:0]   hold_r = '0;
      nkeys = 0; end_t = -1; stab_err = 0; end_done = 1'b0; end_err = 1'b0;
      for (int i = 0; i < 16; i++) begin
         got_rk[i] = 'x; got_round[i] = -1; got_last[i] = 1'bx; got_t[i] = -1;
      end
      req_key = key; req_valid = 1'b1; abort = 1'b0; rk_ready = 1'b0; ke_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = hold_req;
      for (int t = 1; t < 800; t++) begin
         if (!busy) begin
            end_t = t; end_done = done; end_err = err;
            break;
         end
         if (rk_valid) begin
            if (holding) begin
               if (rk_data !== hold_d || rk_round !== hold_r) stab_err++;
            end else if (nkeys < 16) begin
               got_rk[nkeys] = rk_data; got_round[nkeys] = int'(rk_round);
               got_last[nkeys] = rk_last; got_t[nkeys] = t;
               nkeys++;
               holding = 1'b1; hold_d = rk_data; hold_r = rk_round;
            end
         end
         abort    = (t == abort_cyc);
         rk_ready = rnd_rk ? 1'($urandom_range(0, 1)) : 1'b1;
         ke_ready = rnd_ke ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rk_valid && rk_ready && !abort) holding = 1'b0;
         @(posedge clk); #1;
      end
      req_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0; ke_ready = 1'b1;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({rk_valid, done, err, busy, req_ready} !== 5'b00001) begin
         tests_failed++;
         $display("FAIL reset_flags got=%b exp=00001", {rk_valid, done, err, busy, req_ready});
      end
      tests_run++;
      if (rk_data !== '0 || rk_round !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_rk got=%h/%0d exp=0/0", rk_data, rk_round);
      end
   endtask

   task automatic test_fips_key();
      int bad_t = 0, bad_d = 0;
      run_sched(KEY_A, 1'b0, 1'b0, -1, 1'b0);
      tests_run++;
      if (nkeys != 11) begin tests_failed++; $display("FAIL a_nkeys got=%0d exp=11", nkeys); end
      tests_run++;
      if (got_rk[0] !== KEY_A) begin tests_failed++; $display("FAIL a_rk0 got=%h exp=%h", got_rk[0], KEY_A); end
      tests_run++;
      if (got_rk[10] !== A_RK10) begin tests_failed++; $display("FAIL a_rk10 got=%h exp=%h", got_rk[10], A_RK10); end
      tests_run++;
      if (got_last[10] !== 1'b1 || got_last[9] !== 1'b0) begin
         tests_failed++; $display("FAIL a_rk_last got=%b%b exp=10", got_last[10], got_last[9]);
      end
      tests_run++;
      if (end_done !== 1'b1 || end_t != 56) begin
         tests_failed++; $display("FAIL a_done_latency got=%b@%0d exp=1@56", end_done, end_t);
      end
      for (int k = 0; k < 11; k++) begin
         if (got_t[k] != 5 + 5 * k) bad_t++;
         if (got_rk[k] !== exp_rk(KEY_A, k) || got_round[k] != k) bad_d++;
      end
      tests_run++;
      if (bad_t != 0) begin tests_failed++; $display("FAIL a_key_spacing got=%0d_bad exp=0 (rk0 at %0d)", bad_t, got_t[0]); end
      tests_run++;
      if (bad_d != 0) begin tests_failed++; $display("FAIL a_key_model got=%0d_bad exp=0", bad_d); end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0) begin tests_failed++; $display("FAIL a_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_random_ready();
      run_sched(KEY_B, 1'b1, 1'b1, -1, 1'b0);
      tests_run++;
      if (got_rk[1] !== B_RK1) begin tests_failed++; $display("FAIL b_rk1 got=%h exp=%h", got_rk[1], B_RK1); end
      tests_run++;
      if (got_rk[10] !== B_RK10) begin tests_failed++; $display("FAIL b_rk10 got=%h exp=%h", got_rk[10], B_RK10); end
      tests_run++;
      if (stab_err != 0) begin tests_failed++; $display("FAIL b_stable got=%0d exp=0", stab_err); end
      tests_run++;
      if (nkeys != 11 || end_done !== 1'b1) begin
         tests_failed++; $display("FAIL b_complete got=%0d/%b exp=11/1", nkeys, end_done);
      end
   endtask

   task automatic test_random_keys();
      logic [127:0] key;
      int bad;
      for (int n = 0; n < 4; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         run_sched(key, 1'b1, 1'b1, -1, 1'b0);
         bad = 0;
         for (int k = 0; k < 11; k++)
            if (got_rk[k] !== exp_rk(key, k) || got_round[k] != k || got_last[k] !== (k == 10)) bad++;
         tests_run++;
         if (bad != 0 || nkeys != 11 || end_done !== 1'b1 || stab_err != 0) begin
            tests_failed++;
            $display("FAIL rand_key%0d got=%0d_bad/%0d/%b/%0d exp=0/11/1/0", n, bad, nkeys, end_done, stab_err);
         end
      end
   endtask

   task automatic test_abort();
      int seen = 0;
      run_sched(KEY_B, 1'b0, 1'b0, 22, 1'b0);
      tests_run++;
      if (end_t != 23 || end_done !== 1'b0 || nkeys != 4) begin
         tests_failed++;
         $display("FAIL abort_fetch got=t%0d/%b/%0d exp=t23/0/4", end_t, end_done, nkeys);
      end
      for (int i = 0; i < 10; i++) begin
         if (rk_valid || done || busy) seen++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (seen != 0) begin tests_failed++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
      run_sched(KEY_A, 1'b0, 1'b0, -1, 1'b0);
      tests_run++;
      if (got_rk[0] !== KEY_A || nkeys != 11) begin
         tests_failed++; $display("FAIL abort_restart got=%h/%0d exp=%h/11", got_rk[0], nkeys, KEY_A);
      end
   endtask

   task automatic test_addr_check();
      fault_word = 9;
      run_sched(KEY_A, 1'b0, 1'b0, -1, 1'b0);
      fault_word = -1;
      tests_run++;
      if (end_err !== 1'b1 || end_t != 13 || nkeys != 2 || end_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL addr_err got=%b/t%0d/%0d/%b exp=1/t13/2/0", end_err, end_t, nkeys, end_done);
      end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL addr_sticky got=%b exp=1", err); end
      run_sched(KEY_A, 1'b0, 1'b0, -1, 1'b0);
      tests_run++;
      if (end_err !== 1'b0 || nkeys != 11 || got_rk[10] !== A_RK10) begin
         tests_failed++; $display("FAIL addr_clear got=%b/%0d exp=0/11", end_err, nkeys);
      end
   endtask

   task automatic test_back_to_back();
      int v0 = viol, k0 = ks_cnt;
      logic ks;
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1, 1'b1);
      tests_run++;
      if (viol != v0 || ks_cnt - k0 != 1 || end_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_req got=%0d_viol/%0d_start/%b exp=0/1/1", viol - v0, ks_cnt - k0, end_done);
      end
      req_valid = 1'b1; abort = 1'b1; req_key = KEY_A;
      #1 ks = ke_start;
      @(posedge clk); #1;
      req_valid = 1'b0; abort = 1'b0;
      tests_run++;
      if (ks !== 1'b0 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL accept_abort got=%b/%b exp=0/0", ks, busy);
      end
   endtask

`ifdef KSC_LAST_KEY_EN
   task automatic test_last_key();
      run_sched(KEY_A, 1'b0, 1'b0, -1, 1'b0);
      tests_run++;
      if (last_key !== A_RK10 || last_key_valid !== 1'b1 || end_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL last_key got=%h/%b exp=%h/1", last_key, last_key_valid, A_RK10);
      end
   endtask
`endif

   task automatic test_reset_mid();
      req_key = KEY_B; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; rk_ready = 1'b1;
      repeat (12) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({rk_valid, done, busy, err, req_ready} !== 5'b00001 || rk_data !== '0 || rk_round !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_mid got=%b/%h/%0d exp=00001/0/0", {rk_valid, done, busy, err, req_ready}, rk_data, rk_round);
      end
      rk_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      test_fips_key();
      test_random_ready();
      test_random_keys();
      test_abort();
      test_addr_check();
      test_back_to_back();
`ifdef KSC_LAST_KEY_EN
      test_last_key();
`endif
      test_reset_mid();
      tests_run++;
      if (viol != 0) begin tests_failed++; $display("FAIL protocol got=%0d exp=0", viol); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
